pixel_color_writer: RTL
=======================

# pixel_color_writer

Downstream stage of the Mandelbrot grid iterator: accepts one completed pixel per handshake (screen coordinate plus escape-iteration count), maps the count to an 8-bit RGB332 colour, and writes it to the VGA frame-buffer SRAM through a grant-arbitrated write port. A small FIFO decouples the iterator's completion rate from SRAM arbitration stalls. The block also counts written pixels and flags frame completion to the HPS/timer logic.

## Interface
- MAX_ITER, 1000: iteration cap; counts >= MAX_ITER are in-set.
- FIFO_DEPTH, 4: input FIFO entries, power of two, >= 2.
- SCREEN_W, 640: pixels per row.
- SCREEN_H, 480: rows per frame.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  pixel result available.
- in_ready  out  1  FIFO can accept; transfer on in_valid & in_ready at rising edge.
- in_x  in  10  pixel column.
- in_y  in  9  pixel row.
- in_count  in  11  iteration count from iterator.
- mem_addr  out  19  SRAM word address, in_y*SCREEN_W + in_x.
- mem_data  out  8  RGB332 colour.
- mem_we  out  1  write request; held with addr/data stable until granted.
- mem_grant  in  1  write accepted at rising edge when mem_we & mem_grant.
- pixels_written  out  19  pixels written in current frame.
- frame_done  out  1  one-cycle pulse on write of pixel (SCREEN_W-1, SCREEN_H-1).

## Operation
- Reset values: in_ready 0 during reset, 1 the cycle after; mem_we 0; mem_addr 0; mem_data 0; pixels_written 0; frame_done 0; FIFO empty.
- FIFO: stores {x, y, count}; in_ready = (occupancy < FIFO_DEPTH), registered from occupancy. Push and pop on the same edge leave occupancy unchanged. No push when full (in_ready low); in_valid while full is ignored, not lost (source holds).
- Range check on pop: entries with x >= SCREEN_W or y >= SCREEN_H are discarded — popped, no write, not counted, no frame_done.
- Output stage: single register {addr, colour}. Loads from FIFO head when empty or being granted the same edge (back-to-back writes at 1 pixel/cycle with grant high).
- Address: y*SCREEN_W + x, computed unsigned, 19 bits, no truncation for in-range pixels (max 307199).
- Colour map (first match): count >= MAX_ITER -> 8'h00; >= 256 -> 8'h64; >= 128 -> 8'hE4; >= 64 -> 8'hEC; >= 32 -> 8'hFC; >= 16 -> 8'h1F; >= 8 -> 8'h13; else 8'h02.
- mem_we high while output register valid; addr/data must not change until the grant edge.
- On grant edge: pixels_written increments; if addr == SCREEN_W*SCREEN_H-1, frame_done pulses next cycle and pixels_written returns to 0 instead of incrementing.
- Reset mid-operation: FIFO flushed, pending write dropped, mem_we low the cycle after the reset edge, counters cleared; no partial frame_done.

## Timing
- Latency: pixel accepted at edge k with FIFO empty and output stage free -> mem_we high with its addr/data in the cycle after edge k+1.
- Throughput: 1 pixel/cycle with mem_grant tied high; stall fully back-pressures via in_ready once FIFO fills.
- in_ready falls the cycle after the push that fills the FIFO; rises the cycle after the first pop from full.
- frame_done asserted exactly one cycle, registered.

## Test plan
- Single pixel, grant high: push (x=3,y=2,count=1000) -> one write, mem_addr=1283, mem_data=8'h00, pixels_written=1, two cycles after accept.
- Colour bands: counts 0,8,16,32,64,128,256,999 at consecutive x -> mem_data 02,13,1F,FC,EC,E4,64,64 in order.
- Backpressure: grant low, push 6 pixels -> in_ready drops after 5 accepted (4 FIFO + 1 output stage), no mem_we change; raise grant -> all 5 written in order, one per cycle, then 6th accepted.
- Out-of-range: push (x=640,y=0) then (x=0,y=480) then (x=1,y=0) -> only addr 1 written, pixels_written=1.
- Full frame: 307200 pixels raster order, grant toggled randomly -> 307200 writes, correct addresses, frame_done one pulse after last write, pixels_written=0 afterwards.
- Reset mid-stream: FIFO holding 3 entries, grant low, assert reset one cycle -> mem_we 0, pixels_written 0, in_ready 1 after reset release, no stale writes.

Source files
------------

// File: rtl/pixel_color_writer_if.sv
// Pixel-result stream and frame-buffer write port of the Mandelbrot colour writer.
// slave = the writer itself; master = iterator upstream plus the SRAM arbiter.
interface pixel_color_writer_if;
  // Both channels are valid/ready style. A pixel moves when in_valid & in_ready at a rising
  // edge. A write lands when mem_we & mem_grant at a rising edge. While a side waits, it
  // holds its payload steady and keeps its valid (in_valid or mem_we) high.
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_x;
  logic [8:0]  in_y;
  logic [10:0] in_count;
  logic [18:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        mem_grant;

  modport master (
    output in_valid, in_x, in_y, in_count, mem_grant,
    input  in_ready, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  in_valid, in_x, in_y, in_count, mem_grant,
    output in_ready, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/pixel_color_writer.sv
// Buffers completed Mandelbrot pixels, maps iteration counts to RGB332 and writes them to the
// frame buffer through a grant-arbitrated port, counting pixels and flagging frame completion.
module pixel_color_writer #(
  parameter int MAX_ITER   = 1000,
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  pixel_color_writer_if.slave  bus,
  output logic [18:0]          pixels_written,
  output logic                 frame_done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE    = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [10:0]      X_LIMIT    = 11'(SCREEN_W);
  localparam logic [9:0]       Y_LIMIT    = 10'(SCREEN_H);
  localparam logic [18:0]      ROW_STRIDE = 19'(SCREEN_W);
  localparam logic [18:0]      LAST_ADDR  = 19'(SCREEN_W * SCREEN_H - 1);
  localparam logic [10:0]      ITER_CAP   = 11'(MAX_ITER);

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [10:0] count;
  } pixel_t;

  pixel_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;
  logic             in_ready_r;

  pixel_t           head;
  logic             push;
  logic             pop;
  logic             out_free;
  logic             grant_now;
  logic             head_in_range;
  logic [18:0]      head_addr;
  logic [7:0]       head_colour;

  logic             out_valid;
  logic [18:0]      out_addr;
  logic [7:0]       out_data;

  // Escape-speed bands, first match wins; in-set pixels are black.
  function automatic logic [7:0] colour_of(input logic [10:0] count);
    if (count >= ITER_CAP)      return 8'h00;
    else if (count >= 11'd256)  return 8'h64;
    else if (count >= 11'd128)  return 8'hE4;
    else if (count >= 11'd64)   return 8'hEC;
    else if (count >= 11'd32)   return 8'hFC;
    else if (count >= 11'd16)   return 8'h1F;
    else if (count >= 11'd8)    return 8'h13;
    else                        return 8'h02;
  endfunction

  assign push      = bus.in_valid & in_ready_r;
  assign grant_now = out_valid & bus.mem_grant;
  // The output register may take a new pixel when empty or when its current one is granted.
  assign out_free  = ~out_valid | bus.mem_grant;
  assign pop       = (occ != '0) & out_free;

  assign head          = fifo_mem[rd_ptr];
  assign head_in_range = ({1'b0, head.x} < X_LIMIT) && ({1'b0, head.y} < Y_LIMIT);
  assign head_addr     = 19'(head.y) * ROW_STRIDE + 19'(head.x);
  assign head_colour   = colour_of(head.count);

  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + OCC_ONE;
      2'b01:   occ_next = occ - OCC_ONE;
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= pixel_t'({bus.in_x, bus.in_y, bus.in_count});
    end
  end

  // in_ready is registered from the next occupancy so it never depends on in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      in_ready_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      occ        <= occ_next;
      in_ready_r <= (occ_next < OCC_FULL);
    end
  end

  // Off-screen entries are popped but never loaded, so they produce no write.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (out_free) begin
      if (pop && head_in_range) begin
        out_valid <= 1'b1;
        out_addr  <= head_addr;
        out_data  <= head_colour;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixels_written <= '0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= grant_now && (out_addr == LAST_ADDR);
      if (grant_now) begin
        pixels_written <= (out_addr == LAST_ADDR) ? 19'd0 : pixels_written + 19'd1;
      end
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.mem_we   = out_valid;
  assign bus.mem_addr = out_addr;
  assign bus.mem_data = out_data;

endmodule
